riscv_ifetch: RTL and testbench

Instruction fetch unit for the RV32I core. It is the initiator side of the instruction-memory read port. It owns the fetch PC and drives the word address to the instruction memory. The memory returns data combinationally in the same cycle, and this block captures each returned word together with its PC into a 2-entry buffer. The buffer feeds decode through a valid/ready handshake, and the block supports redirects (branch/jump/trap) that flush the buffer and halt on misaligned targets.

---
 rtl/riscv_ifetch.sv | 122 ++++++++++++
 tb/tb_riscv_ifetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ifetch.sv
// RV32I instruction fetch: owns the fetch PC, reads a combinational instruction
// memory and queues {pc, inst} pairs in a 2-entry buffer toward decode.
`timescale 1ns/1ps

`ifndef XLEN
`define XLEN 32
`endif
`ifndef IMEM_ADDR_BIT
`define IMEM_ADDR_BIT 10
`endif

module riscv_ifetch #(
  parameter logic [`XLEN-1:0] RESET_PC = '0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  output logic [`IMEM_ADDR_BIT-3:0] o_imem_addr,
  input  logic [`XLEN-1:0]          i_imem_data,
  output logic                      o_inst_valid,
  output logic [`XLEN-1:0]          o_inst,
  output logic [`XLEN-1:0]          o_inst_pc,
  input  logic                      i_inst_ready,
  input  logic                      i_redirect,
  input  logic [`XLEN-1:0]          i_redirect_pc,
  output logic                      o_misalign
);

  localparam int AW = `IMEM_ADDR_BIT;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_e;

  state_e           state_q;
  logic [`XLEN-1:0] fpc_q;
  logic [1:0]       count_q;
  logic             head_q;
  logic             misalign_q;

  logic [`XLEN-1:0] buf_pc_q   [2];
  logic [`XLEN-1:0] buf_inst_q [2];

  logic             pop;
  logic             push;
  logic             tail;
  logic [1:0]       count_d;

  assign pop  = (count_q != 2'd0) && i_inst_ready;
  assign push = (state_q == FETCH) && !i_redirect && ((count_q != 2'd2) || pop);

  // With one entry the tail is the other slot; when full, a push only happens
  // alongside a pop, so it reuses the slot the head is vacating.
  assign tail = head_q ^ (count_q == 2'd1);

  always_comb begin
    // NOTE: give every combinational output a default first so no path leaves it unassigned and infers a latch.
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= FETCH;
      fpc_q      <= RESET_PC;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else if (i_redirect) begin
      fpc_q   <= i_redirect_pc;
      count_q <= 2'd0;
      head_q  <= 1'b0;
      if (i_redirect_pc[1:0] == 2'b00) begin
        state_q    <= FETCH;
        misalign_q <= 1'b0;
      end else begin
        state_q    <= HALT;
        misalign_q <= 1'b1;
      end
    end else begin
      count_q <= count_d;
      if (pop) begin
        head_q <= ~head_q;
      end
      if (push) begin
        fpc_q <= fpc_q + `XLEN'(4);
      end
    end
  end

  // NOTE: buffer storage is not reset; outputs are masked by count, so stale contents are never visible.
  always_ff @(posedge i_clk) begin
    if (push) begin
      buf_pc_q[tail]   <= fpc_q;
      buf_inst_q[tail] <= i_imem_data;
    end
  end

  assign o_imem_addr  = fpc_q[AW-1:2];
  assign o_inst_valid = (count_q != 2'd0);
  assign o_inst       = o_inst_valid ? buf_inst_q[head_q] : '0;
  assign o_inst_pc    = o_inst_valid ? buf_pc_q[head_q]   : '0;
  assign o_misalign   = misalign_q;

`ifndef SYNTHESIS
  a_count_range: assert property (@(posedge i_clk) disable iff (i_rst)
    count_q <= 2'd2);

  a_halt_empty: assert property (@(posedge i_clk) disable iff (i_rst)
    (state_q == HALT) |-> (count_q == 2'd0));

  a_head_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_inst_valid && !i_inst_ready && !i_redirect)
      |=> ($stable(o_inst) && $stable(o_inst_pc) && o_inst_valid));
`endif

endmodule

// File: tb/tb_riscv_ifetch.sv
// Directed bench for riscv_ifetch: expected accepted (pc, inst) pairs go into a
// scoreboard queue that a negedge monitor drains on every decode handshake.
`timescale 1ns/1ps

`ifndef XLEN
`define XLEN 32
`endif
`ifndef IMEM_ADDR_BIT
`define IMEM_ADDR_BIT 10
`endif

module tb_riscv_ifetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic                      clk;
  logic                      rst;
  logic [`IMEM_ADDR_BIT-3:0] imem_addr;
  logic [`XLEN-1:0]          imem_data;
  logic                      inst_valid;
  logic [`XLEN-1:0]          inst;
  logic [`XLEN-1:0]          inst_pc;
  logic                      inst_ready;
  logic                      redirect;
  logic [`XLEN-1:0]          redirect_pc;
  logic                      misalign;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  riscv_ifetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_imem_addr   (imem_addr),
    .i_imem_data   (imem_data),
    .o_inst_valid  (inst_valid),
    .o_inst        (inst),
    .o_inst_pc     (inst_pc),
    .i_inst_ready  (inst_ready),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_misalign    (misalign)
  );

  // Memory word k holds 0x1000_0000 + k.
  assign imem_data = 32'h1000_0000 + 32'(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] word);
    sb_q.push_back('{pc: pc, inst: word});
  endtask

  // Monitor: every accepted head (not cancelled by redirect or reset) must match the queue front.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && inst_valid && inst_ready && !redirect) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: got pc %h, expected no transfer", inst_pc);
        end else begin
          e = sb_q.pop_front();
          check("sb_pc", inst_pc, e.pc);
          check("sb_inst", inst, e.inst);
        end
      end
    end
  end

  initial begin
    #100000;
    n_total++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    rst = 1'b1; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(inst_valid), 0);
    check("rst_inst", inst, 0);
    check("rst_pc", inst_pc, 0);
    check("rst_misalign", 32'(misalign), 0);
    check("rst_addr", 32'(imem_addr), 0);

    // Reset fetch, then a decode stall and release.
    expect_entry(32'h0, 32'h1000_0000);
    expect_entry(32'h4, 32'h1000_0001);
    expect_entry(32'h8, 32'h1000_0002);
    rst = 1'b0; inst_ready = 1'b1;
    check("fetch_addr0", 32'(imem_addr), 0);
    tick();
    check("fetch_addr1", 32'(imem_addr), 1);
    check("fetch_valid", 32'(inst_valid), 1);
    tick();
    check("fetch_addr2", 32'(imem_addr), 2);
    inst_ready = 1'b0;
    tick();
    check("stall_addr_fill", 32'(imem_addr), 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr_hold", 32'(imem_addr), 3);
      check("stall_head_pc", inst_pc, 32'h4);
      check("stall_head_inst", inst, 32'h1000_0001);
      check("stall_valid", 32'(inst_valid), 1);
    end
    inst_ready = 1'b1;
    tick();
    check("release_addr4", 32'(imem_addr), 4);
    tick();
    check("release_addr5", 32'(imem_addr), 5);
    check("release_head_pc", inst_pc, 32'hC);

    // Redirect on a full buffer with a simultaneous pop.
    expect_entry(32'h40, 32'h1000_0010);
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0; inst_ready = 1'b0;
    check("redir_bubble", 32'(inst_valid), 0);
    check("redir_addr", 32'(imem_addr), 16);
    tick();
    check("redir_valid", 32'(inst_valid), 1);
    check("redir_pc", inst_pc, 32'h40);
    check("redir_inst", inst, 32'h1000_0010);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;

    // Misaligned redirect halts fetch until an aligned redirect.
    redirect = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect = 1'b0; inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("halt_misalign", 32'(misalign), 1);
      check("halt_valid", 32'(inst_valid), 0);
      check("halt_addr", 32'(imem_addr), 16);
      tick();
    end
    expect_entry(32'h80, 32'h1000_0020);
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    check("unhalt_misalign", 32'(misalign), 0);
    check("unhalt_bubble", 32'(inst_valid), 0);
    check("unhalt_addr", 32'(imem_addr), 32);
    tick();
    check("unhalt_pc", inst_pc, 32'h80);
    tick();
    inst_ready = 1'b0;

    // Address wrap at the top of a 1 KiB memory.
    expect_entry(32'h3FC, 32'h1000_00FF);
    expect_entry(32'h400, 32'h1000_0000);
    redirect = 1'b1; redirect_pc = 32'h3FC;
    tick();
    redirect = 1'b0;
    check("wrap_addr_top", 32'(imem_addr), 255);
    inst_ready = 1'b1;
    tick();
    check("wrap_pc_top", inst_pc, 32'h3FC);
    check("wrap_addr_zero", 32'(imem_addr), 0);
    tick();
    check("wrap_pc_over", inst_pc, 32'h400);
    check("wrap_inst_over", inst, 32'h1000_0000);
    tick();
    inst_ready = 1'b0;
    tick();
    tick();
    check("prefill_addr", 32'(imem_addr), 3);

    // Asynchronous reset between edges with a full buffer.
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(inst_valid), 0);
    check("arst_inst", inst, 0);
    check("arst_pc", inst_pc, 0);
    check("arst_addr", 32'(imem_addr), 0);
    expect_entry(32'h0, 32'h1000_0000);
    expect_entry(32'h4, 32'h1000_0001);
    tick();
    rst = 1'b0; inst_ready = 1'b1;
    tick();
    tick();
    tick();
    inst_ready = 1'b0;
    check("restart_head_pc", inst_pc, 32'h8);
    tick();

    check("sb_drained", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
